// File: rtl/dram_v5_pkg.sv
// dram_v5_pkg: MIG command codes, burst geometry and requester-index sizing shared by the DRAM arbiter.
package dram_v5_pkg;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int BEATS_PER_BURST = 2;
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dram_tag_fifo.sv
// dram_tag_fifo: small synchronous FIFO holding the requester index of each outstanding read burst.
module dram_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = r_mem[r_rp];
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/dram_app_arbiter.sv
// dram_app_arbiter: round-robin sharing of the V5 MIG user interface; splits write bursts into two
// app beats and steers in-order read returns back to the issuing requester via a tag FIFO.
module dram_app_arbiter
  import dram_v5_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_WIDTH = 31,
  parameter int APPDATA_WIDTH = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                              clk_sys,
  input  logic                              sys_rst,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ-1:0]                   req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0]        req_addr,
  input  logic [NREQ*2*APPDATA_WIDTH-1:0]   req_wdata,
  input  logic [NREQ*APPDATA_WIDTH/4-1:0]   req_wmask,
  output logic [NREQ-1:0]                   rsp_valid,
  output logic                              rsp_last,
  output logic [APPDATA_WIDTH-1:0]          rsp_data,
  input  logic                              phy_init_done,
  input  logic                              app_af_afull,
  input  logic                              app_wf_afull,
  output logic                              app_af_wren,
  output logic [2:0]                        app_cmd,
  output logic [ADDR_WIDTH-1:0]             app_addr,
  output logic                              app_wf_wren,
  output logic [APPDATA_WIDTH-1:0]          app_data,
  output logic [APPDATA_WIDTH/8-1:0]        app_mask,
  input  logic                              app_rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]          app_rd_data,
  output logic                              rd_err
);
  localparam int IW = req_idx_w(NREQ);
  localparam int MW = APPDATA_WIDTH/8;
  localparam int BW = 2*APPDATA_WIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WR2 = 1'b1;
  logic [0:0] r_state;
  logic [IW-1:0] r_rr;
  logic [APPDATA_WIDTH-1:0] r_beat1;
  logic [MW-1:0] r_mask1;
  logic r_beat;
  logic [NREQ-1:0] w_elig;
  logic [ADDR_WIDTH-1:0] w_addr_a [NREQ];
  logic [BW-1:0] w_data_a [NREQ];
  logic [2*MW-1:0] w_mask_a [NREQ];
  logic [IW-1:0] w_win, w_idx, w_head;
  logic w_any, w_wr, w_tag_full, w_tag_empty, w_rd_ok;
  logic [BW-1:0] w_data;
  logic [2*MW-1:0] w_mask;
  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign w_addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_a[g] = req_wdata[g*BW +: BW];
    assign w_mask_a[g] = req_wmask[g*2*MW +: 2*MW];
    assign w_elig[g] = req_valid[g] && r_state == IDLE && phy_init_done && !app_af_afull &&
                       (req_write[g] ? !app_wf_afull : !w_tag_full);
  end
  // scan downward so the nearest eligible requester at or after r_rr overwrites the rest
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr) + k) % NREQ);
      w_win = w_elig[w_idx] ? w_idx : w_win;
    end
  end
  assign w_any = |w_elig;
  assign req_ready = w_any ? NREQ'(1) << w_win : '0;
  assign w_wr = req_write[w_win];
  assign w_data = w_data_a[w_win];
  assign w_mask = w_mask_a[w_win];
  assign w_rd_ok = app_rd_data_valid && !w_tag_empty;
  dram_tag_fifo #(.DEPTH(TAG_DEPTH), .W(IW)) u_tags (
    .clk(clk_sys),
    .rst(sys_rst),
    .i_push(w_any && !w_wr),
    .i_data(w_win),
    .i_pop(w_rd_ok && r_beat == 1'(BEATS_PER_BURST-1)),
    .o_data(w_head),
    .o_full(w_tag_full),
    .o_empty(w_tag_empty)
  );
  always_ff @(posedge clk_sys or posedge sys_rst)
    if (sys_rst) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_beat1 <= '0;
      r_mask1 <= '0;
      r_beat <= 1'b0;
      app_af_wren <= 1'b0;
      app_cmd <= '0;
      app_addr <= '0;
      app_wf_wren <= 1'b0;
      app_data <= '0;
      app_mask <= '0;
      rsp_valid <= '0;
      rsp_last <= 1'b0;
      rsp_data <= '0;
      rd_err <= 1'b0;
    end else begin
      app_af_wren <= 1'b0;
      app_wf_wren <= 1'b0;
      if (r_state == WR2) begin
        app_wf_wren <= 1'b1;
        app_data <= r_beat1;
        app_mask <= r_mask1;
        r_state <= IDLE;
      end else if (w_any) begin
        app_af_wren <= 1'b1;
        app_cmd <= w_wr ? CMD_WR : CMD_RD;
        app_addr <= w_addr_a[w_win];
        r_rr <= IW'((int'(w_win) + 1) % NREQ);
        if (w_wr) begin
          app_wf_wren <= 1'b1;
          app_data <= w_data[APPDATA_WIDTH-1:0];
          app_mask <= w_mask[MW-1:0];
          r_beat1 <= w_data[BW-1:APPDATA_WIDTH];
          r_mask1 <= w_mask[2*MW-1:MW];
          r_state <= WR2;
        end
      end
      rsp_valid <= w_rd_ok ? NREQ'(1) << w_head : '0;
      rsp_last <= w_rd_ok && r_beat;
      rsp_data <= app_rd_data;
      r_beat <= r_beat ^ w_rd_ok;
      rd_err <= rd_err | (app_rd_data_valid && w_tag_empty);
    end
endmodule
